// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Command sequencer placed directly upstream of the 4-bit combinational ALU.
// The block accepts one ALU command at a time over a valid/ready handshake.
// It drives the ALU operand and select inputs from registers. One cycle
// later it captures the ALU result, carry and zero flags, and presents them
// downstream over a second valid/ready handshake. An internal 4-bit
// accumulator holds the last captured result, so a command can reuse it as
// operand A.
//
// Optional feature macro: ALU_SEQ_CARRY_CNT_EN
//   defined   : carry_cnt is an 8-bit saturating count of responses with carry=1
//   undefined : no counter register is built and carry_cnt is tied to 8'h00
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (cmd_ready is 1 only in IDLE)
//   cmd_op, cmd_a, cmd_b    ALU select code and operands
//   cmd_acc                 1 = use the accumulator as operand A
//   alu_a, alu_b, alu_sel   registered operands/select driven to the ALU
//   alu_result/carry/zero   combinational ALU outputs fed back in
//   rsp_valid/rsp_ready     response handshake
//   rsp_result/carry/zero   captured ALU outputs
//   acc                     current accumulator value
//   carry_cnt               saturating count of carry responses (see macro)
// ---------------------------------------------------------------------------
module alu_cmd_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic       cmd_acc,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_zero,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic [3:0] acc,
    output logic [7:0] carry_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q,      state_d;
    logic [3:0] alu_a_q,      alu_a_d;
    logic [3:0] alu_b_q,      alu_b_d;
    logic [2:0] alu_sel_q,    alu_sel_d;
    logic [3:0] rsp_result_q, rsp_result_d;
    logic       rsp_carry_q,  rsp_carry_d;
    logic       rsp_zero_q,   rsp_zero_d;
    logic [3:0] acc_q,        acc_d;

    // Both handshake outputs depend only on the current state. This keeps
    // any combinational path from cmd_valid or rsp_ready out of the outputs.
    assign cmd_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = rsp_zero_q;
    assign acc        = acc_q;

    // Next-state and datapath logic. Each register holds its value by default.
    // Operands load only when a command is accepted in IDLE.
    // The response fields and the accumulator load only at the end of the
    // single EXEC cycle, once the ALU has settled on the registered operands.
    // Undefined op codes pass to the ALU unchanged. Whatever the ALU returns
    // is captured like any other result.
    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
        acc_d        = acc_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    alu_sel_d = cmd_op;
                    alu_b_d   = cmd_b;
                    alu_a_d   = cmd_acc ? acc_q : cmd_a;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_carry_d  = alu_carry;
                rsp_zero_d   = alu_zero;
                acc_d        = alu_result;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset takes priority over everything.
    // A command in flight during reset is dropped, and no response is issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            alu_a_q      <= 4'h0;
            alu_b_q      <= 4'h0;
            alu_sel_q    <= 3'b000;
            rsp_result_q <= 4'h0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            acc_q        <= 4'h0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
            acc_q        <= acc_d;
        end
    end

`ifdef ALU_SEQ_CARRY_CNT_EN
    logic [7:0] carry_cnt_q, carry_cnt_d;

    // The carry counter advances together with the EXEC capture whenever the
    // ALU reports a carry. It stops at 8'hFF instead of wrapping to zero.
    always_comb begin
        carry_cnt_d = carry_cnt_q;
        if ((state_q == EXEC) && alu_carry && (carry_cnt_q != 8'hFF)) begin
            carry_cnt_d = carry_cnt_q + 8'd1;
        end
    end

    // Carry counter register. It clears with the rest of the state on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_cnt_q <= 8'h00;
        end else begin
            carry_cnt_q <= carry_cnt_d;
        end
    end

    assign carry_cnt = carry_cnt_q;
`else
    assign carry_cnt = 8'h00;
`endif

endmodule
